// File: rtl/classifier_pkg.sv
// Shared types and default widths for the classifier stream arbiter and its skid stage.
package classifier_pkg;

  localparam int CLS_DATA_WIDTH = 32;
  localparam int CLS_KEEP_WIDTH = CLS_DATA_WIDTH / 8;
  localparam int CLS_CNT_WIDTH  = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_e;

  typedef logic src_id_t;

  localparam src_id_t SRC0 = 1'b0;
  localparam src_id_t SRC1 = 1'b1;

endpackage

// File: rtl/classifier_axis_skid.sv
// Two-entry registered skid buffer carrying {data, keep, last, id}.
// The output entry drives m_* directly; upstream ready is the registered "second entry empty" flag.
module classifier_axis_skid
  import classifier_pkg::*;
#(
  parameter int DATA_WIDTH = CLS_DATA_WIDTH,
  parameter int KEEP_WIDTH = CLS_KEEP_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic [KEEP_WIDTH-1:0] s_tkeep,
  input  logic                  s_tlast,
  input  src_id_t               s_tid,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic [KEEP_WIDTH-1:0] m_tkeep,
  output logic                  m_tlast,
  output src_id_t               m_tid,
  output logic                  m_tvalid,
  input  logic                  m_tready
);

  localparam int PAY_W = DATA_WIDTH + KEEP_WIDTH + 2;

  logic [PAY_W-1:0] pay_in;
  logic [PAY_W-1:0] pay_p0;
  logic [PAY_W-1:0] pay_p1;
  logic             vld_p0;
  logic             vld_p1;
  logic             push;
  logic             pop;

  assign pay_in   = {s_tdata, s_tkeep, s_tlast, s_tid};
  assign s_tready = ~vld_p1;
  assign push     = s_tvalid & ~vld_p1;
  assign pop      = vld_p0 & m_tready;

  // Stage p0 is the output register, p1 catches the beat that arrives while p0 is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      pay_p0 <= '0;
      pay_p1 <= '0;
    end else if (vld_p1) begin
      if (pop) begin
        pay_p0 <= pay_p1;
        vld_p1 <= 1'b0;
      end
    end else if (!vld_p0 || pop) begin
      vld_p0 <= push;
      if (push) pay_p0 <= pay_in;
    end else if (push) begin
      pay_p1 <= pay_in;
      vld_p1 <= 1'b1;
    end
  end

  assign {m_tdata, m_tkeep, m_tlast, m_tid} = pay_p0;
  assign m_tvalid = vld_p0;

endmodule

// File: rtl/classifier_stream_arbiter.sv
// Packet-level round-robin arbiter sharing the classifier AXI-Stream input between two sources.
// Optional per-source packet counters are built when CLASSIFIER_ARB_STATS_EN is defined.
module classifier_stream_arbiter
  import classifier_pkg::*;
#(
  parameter int DATA_WIDTH = CLS_DATA_WIDTH,
  parameter int KEEP_WIDTH = CLS_KEEP_WIDTH,
  parameter int CNT_WIDTH  = CLS_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s0_axis_tkeep,
  input  logic                  s0_axis_tvalid,
  input  logic                  s0_axis_tlast,
  output logic                  s0_axis_tready,
  input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s1_axis_tkeep,
  input  logic                  s1_axis_tvalid,
  input  logic                  s1_axis_tlast,
  output logic                  s1_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tid,
  input  logic                  m_axis_tready,
  output logic [CNT_WIDTH-1:0]  pkt_cnt0,
  output logic [CNT_WIDTH-1:0]  pkt_cnt1
);

  arb_state_e            state;
  arb_state_e            state_nxt;
  src_id_t               last_grant;
  logic [DATA_WIDTH-1:0] sk_tdata;
  logic [KEEP_WIDTH-1:0] sk_tkeep;
  logic                  sk_tlast;
  src_id_t               sk_tid;
  logic                  sk_tvalid;
  logic                  sk_tready;
  logic                  fire0;
  logic                  fire1;

  assign fire0 = (state == GRANT0) && s0_axis_tvalid && sk_tready;
  assign fire1 = (state == GRANT1) && s1_axis_tvalid && sk_tready;

  always_comb begin
    state_nxt      = state;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    sk_tvalid      = 1'b0;
    sk_tdata       = s0_axis_tdata;
    sk_tkeep       = s0_axis_tkeep;
    sk_tlast       = s0_axis_tlast;
    sk_tid         = SRC0;
    unique case (state)
      IDLE: begin
        // On a tie the source that did not win last time gets the grant.
        if (s0_axis_tvalid && s1_axis_tvalid)
          state_nxt = (last_grant == SRC1) ? GRANT0 : GRANT1;
        else if (s0_axis_tvalid)
          state_nxt = GRANT0;
        else if (s1_axis_tvalid)
          state_nxt = GRANT1;
      end
      GRANT0: begin
        s0_axis_tready = sk_tready;
        sk_tvalid      = s0_axis_tvalid;
        if (fire0 && s0_axis_tlast) state_nxt = IDLE;
      end
      GRANT1: begin
        s1_axis_tready = sk_tready;
        sk_tvalid      = s1_axis_tvalid;
        sk_tdata       = s1_axis_tdata;
        sk_tkeep       = s1_axis_tkeep;
        sk_tlast       = s1_axis_tlast;
        sk_tid         = SRC1;
        if (fire1 && s1_axis_tlast) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= SRC1;
    end else begin
      state <= state_nxt;
      if (fire0 && s0_axis_tlast) last_grant <= SRC0;
      else if (fire1 && s1_axis_tlast) last_grant <= SRC1;
    end
  end

  classifier_axis_skid #(
    .DATA_WIDTH(DATA_WIDTH),
    .KEEP_WIDTH(KEEP_WIDTH)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_tdata (sk_tdata),
    .s_tkeep (sk_tkeep),
    .s_tlast (sk_tlast),
    .s_tid   (sk_tid),
    .s_tvalid(sk_tvalid),
    .s_tready(sk_tready),
    .m_tdata (m_axis_tdata),
    .m_tkeep (m_axis_tkeep),
    .m_tlast (m_axis_tlast),
    .m_tid   (m_axis_tid),
    .m_tvalid(m_axis_tvalid),
    .m_tready(m_axis_tready)
  );

`ifdef CLASSIFIER_ARB_STATS_EN
  logic [CNT_WIDTH-1:0] cnt0_q;
  logic [CNT_WIDTH-1:0] cnt1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (fire0 && s0_axis_tlast) cnt0_q <= cnt0_q + CNT_WIDTH'(1);
      if (fire1 && s1_axis_tlast) cnt1_q <= cnt1_q + CNT_WIDTH'(1);
    end
  end

  assign pkt_cnt0 = cnt0_q;
  assign pkt_cnt1 = cnt1_q;
`else
  assign pkt_cnt0 = '0;
  assign pkt_cnt1 = '0;
`endif

endmodule
